// File: rtl/mult_pkg.sv
// Shared parameters and helpers for the multiplier datapath and its downstream stages.
// Pure declarations; no logic, latency or backpressure of its own.
package mult_pkg;

  localparam int PW_DEF    = 16;
  localparam int ACC_W_DEF = 18;
  localparam int LEN_DEF   = 4;

  // Width of a counter that walks 0..len-1.
  function automatic int cnt_w(input int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Unsigned ACC_W + PW saturating adder; combinational, zero latency, no handshake.
// o_sat flags that the true sum exceeded 2^ACC_W-1 and o_sum was clamped.
module sat_add #(
  parameter int ACC_W = 18,
  parameter int PW    = 16
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [PW-1:0]    i_prod,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_sat
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, i_acc} + (ACC_W+1)'(i_prod);
  assign o_sat  = w_full[ACC_W];
  assign o_sum  = o_sat ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of LEN products into a saturating dot product; result visible 1 cycle after last beat.
// Input never stalls: a completed group that finds the result register still held is dropped and sets overrun.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN   = LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             overrun
);

  localparam int CW = cnt_w(LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LEN - 1);

  logic [CW-1:0]    r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_ovf;
  logic             r_overrun;

  logic [ACC_W-1:0] w_sum;
  logic             w_sat;
  logic             w_last;
  logic             w_grp_ovf;
  logic             w_consume;
  logic             w_can_load;

  sat_add #(
    .ACC_W (ACC_W),
    .PW    (PW)
  ) u_sat_add (
    .i_acc  (r_acc),
    .i_prod (in_data),
    .o_sum  (w_sum),
    .o_sat  (w_sat)
  );

  assign w_last     = in_valid && (r_cnt == LAST_BEAT);
  assign w_grp_ovf  = r_ovf | w_sat;
  assign w_consume  = r_out_valid && out_ready;
  // A held result may be replaced only in the same edge that hands it downstream.
  assign w_can_load = !r_out_valid || w_consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        if (w_last) begin
          r_cnt <= '0;
          r_acc <= '0;
          r_ovf <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          r_acc <= w_sum;
          r_ovf <= w_grp_ovf;
        end
      end

      if (w_last) begin
        if (w_can_load) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_sum;
          r_out_ovf   <= w_grp_ovf;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives a default-width and a 17-bit-accumulator instance with shared stimulus and
// scores both against an arithmetic model of group sums and result-register occupancy.
module tb_product_accumulator;

  localparam int LEN = 4;
  localparam longint MAX0 = 64'd262143;
  localparam longint MAX1 = 64'd131071;

  typedef struct {
    longint d;
    bit     o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        ov0, oo0, ovr0;
  logic [17:0] od0;
  logic        ov1, oo1, ovr1;
  logic [16:0] od1;

  int n_checks = 0;
  int n_fail   = 0;

  res_t   q0[$];
  res_t   q1[$];
  longint mdl_total[2];
  int     mdl_beats[2];
  bit     mdl_full[2];
  bit     mdl_ovr[2];
  longint mdl_last_d[2];
  bit     mdl_last_o[2];

  always #5 clk = ~clk;

  product_accumulator dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (ov0),
    .out_ready (out_ready),
    .out_data  (od0),
    .out_ovf   (oo0),
    .overrun   (ovr0)
  );

  product_accumulator #(.PW(16), .ACC_W(17), .LEN(LEN)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (ov1),
    .out_ready (out_ready),
    .out_data  (od1),
    .out_ovf   (oo1),
    .overrun   (ovr1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a group is just LEN accepted products; the sum clamps once at the end
  // since unsigned partial sums only grow. The result register is a one-entry slot.
  task automatic model_step(input int k);
    longint mx;
    longint s;
    bit     o;
    bit     done;
    bit     cons;
    mx = (k == 0) ? MAX0 : MAX1;
    if (rst) begin
      mdl_total[k]  = 0;
      mdl_beats[k]  = 0;
      mdl_full[k]   = 0;
      mdl_ovr[k]    = 0;
      mdl_last_d[k] = 0;
      mdl_last_o[k] = 0;
      if (k == 0) q0.delete(); else q1.delete();
    end else begin
      done = 0;
      s    = 0;
      o    = 0;
      if (in_valid) begin
        mdl_total[k] += longint'(in_data);
        mdl_beats[k]++;
        if (mdl_beats[k] == LEN) begin
          done = 1;
          o    = mdl_total[k] > mx;
          s    = o ? mx : mdl_total[k];
          mdl_total[k] = 0;
          mdl_beats[k] = 0;
        end
      end
      cons = mdl_full[k] && out_ready;
      if (done) begin
        if (!mdl_full[k] || cons) begin
          mdl_full[k]   = 1;
          mdl_last_d[k] = s;
          mdl_last_o[k] = o;
          if (k == 0) q0.push_back('{d: s, o: o});
          else        q1.push_back('{d: s, o: o});
        end else begin
          mdl_ovr[k] = 1;
        end
      end else if (cons) begin
        mdl_full[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic monitor_inst(input int k, input logic ov, input longint od,
                              input logic oo, input logic ovr);
    res_t r;
    chk($sformatf("out_valid[%0d]", k), longint'(ov), longint'(mdl_full[k]));
    chk($sformatf("out_data_hold[%0d]", k), od, mdl_last_d[k]);
    chk($sformatf("out_ovf_hold[%0d]", k), longint'(oo), longint'(mdl_last_o[k]));
    chk($sformatf("overrun[%0d]", k), longint'(ovr), longint'(mdl_ovr[k]));
    if (ov && out_ready && !rst) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        chk($sformatf("unexpected_result[%0d]", k), od, -1);
      end else begin
        r = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sb_data[%0d]", k), od, r.d);
        chk($sformatf("sb_ovf[%0d]", k), longint'(oo), longint'(r.o));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mdl_beats[0] >= 0) begin
      monitor_inst(0, ov0, longint'(od0), oo0, ovr0);
      monitor_inst(1, ov1, longint'(od1), oo1, ovr1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    step();
  endtask

  task automatic reset_pulse();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    chk("rst_out_valid", longint'(ov0) + longint'(ov1), 0);
    chk("rst_out_data", longint'(od0) + longint'(od1), 0);
    chk("rst_out_ovf", longint'(oo0) + longint'(oo1), 0);
    chk("rst_overrun", longint'(ovr0) + longint'(ovr1), 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mdl_total[k] = 0; mdl_beats[k] = 0; mdl_full[k] = 0;
      mdl_ovr[k] = 0; mdl_last_d[k] = 0; mdl_last_o[k] = 0;
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    reset_pulse();

    // Basic group
    beat(16'd50); beat(16'd700); beat(16'd40000); beat(16'd990);
    chk("basic_valid", longint'(ov0), 1);
    chk("basic_sum", longint'(od0), 41740);
    chk("basic_ovf", longint'(oo0), 0);
    bubble();
    chk("basic_one_cycle", longint'(ov0), 0);

    // Bubbles between beats
    beat(16'd50); bubble(); beat(16'd700); bubble(); bubble();
    beat(16'd40000); bubble(); beat(16'd990);
    chk("bubble_valid", longint'(ov0), 1);
    chk("bubble_sum", longint'(od0), 41740);
    bubble();

    // Saturation only in the 17-bit instance
    for (int i = 0; i < 4; i++) beat(16'd65025);
    chk("sat_sum17", longint'(od1), 131071);
    chk("sat_ovf17", longint'(oo1), 1);
    chk("nosat_sum18", longint'(od0), 260100);
    chk("nosat_ovf18", longint'(oo0), 0);
    for (int i = 0; i < 4; i++) beat(16'd1);
    chk("post_sat_sum", longint'(od1), 4);
    chk("post_sat_ovf", longint'(oo1), 0);
    bubble();

    // Backpressure and overrun
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(16'd10);
    chk("bp_first_sum", longint'(od0), 40);
    chk("bp_no_overrun", longint'(ovr0), 0);
    for (int i = 0; i < 4; i++) beat(16'd20);
    chk("bp_overrun", longint'(ovr0), 1);
    chk("bp_held_sum", longint'(od0), 40);
    chk("bp_still_valid", longint'(ov0), 1);
    out_ready = 1'b1;
    bubble();
    chk("bp_drained", longint'(ov0), 0);
    chk("bp_overrun_sticky", longint'(ovr0), 1);
    reset_pulse();

    // Simultaneous consume and load
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(16'd5);
    bubble(); bubble();
    beat(16'd7); beat(16'd7); beat(16'd7);
    out_ready = 1'b1;
    beat(16'd7);
    chk("simul_valid", longint'(ov0), 1);
    chk("simul_sum", longint'(od0), 28);
    chk("simul_overrun", longint'(ovr0), 0);
    bubble();

    // Reset mid-group
    beat(16'd100); beat(16'd100);
    reset_pulse();
    beat(16'd1); beat(16'd2); beat(16'd3); beat(16'd4);
    chk("midrst_sum", longint'(od0), 10);
    chk("midrst_valid", longint'(ov0), 1);
    bubble();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      in_data   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(60000, 65535))
                                              : 16'($urandom_range(0, 65535));
      out_ready = (c % 400 < 200) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    step();

    chk("pending0", longint'(q0.size()), longint'(mdl_full[0]));
    chk("pending1", longint'(q1.size()), longint'(mdl_full[1]));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
